uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_pkg.sv | 6 +
 rtl/uart_tick.sv | 21 ++
 rtl/uart_rx.sv | 118 +++++++++++
 tb/tb_uart_rx.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared receiver state encoding and frame constants
package uart_rx_pkg;
  localparam int DATA_BITS = 8;
  localparam int OVS_DEFAULT = 16;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} rx_state_e;
endpackage

// File: rtl/uart_tick.sv
// uart_tick: oversample tick generator, one tick every div+1 enabled clocks
module uart_tick #(
  parameter int BBITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic [BBITS-1:0] div,
  output logic             tick
);
  logic [BBITS-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = en && !restart && cnt_q == div;
    cnt_d = (!en || restart || cnt_q == div) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 receiver with a one-byte valid/ready holding register
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BBITS = 16,
  parameter int OVS   = OVS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BBITS-1:0] baud_div,
  input  logic             rxd,
  input  logic             rdy,
  output logic [7:0]       data,
  output logic             vld,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);
  localparam int SW = $clog2(OVS);
  localparam int CW = $clog2(DATA_BITS);
  rx_state_e     state_q, state_d;
  logic          sync_q, rxs_q, prev_q;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d, data_q, data_d;
  logic          vld_q, vld_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic          tick, fall, last, done;
  uart_tick #(.BBITS(BBITS)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .en      (busy),
    .restart (fall),
    .div     (baud_div),
    .tick    (tick)
  );
  assign busy      = state_q != IDLE;
  assign data      = data_q;
  assign vld       = vld_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    done    = 1'b0;
    ferr_d  = 1'b0;
    fall    = state_q == IDLE && prev_q && !rxs_q;
    last    = tick && scnt_q == SW'(OVS - 1);
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          scnt_d  = '0;
        end
      end
      START: begin
        if (tick) begin
          scnt_d = scnt_q + 1'b1;
          if (scnt_q == SW'(OVS / 2 - 1)) begin
            state_d = rxs_q ? IDLE : DATA;
            scnt_d  = '0;
            bcnt_d  = '0;
          end
        end
      end
      DATA: begin
        if (tick) scnt_d = last ? '0 : scnt_q + 1'b1;
        if (last) begin
          shift_d = {rxs_q, shift_q[7:1]};
          bcnt_d  = bcnt_q + 1'b1;
          state_d = bcnt_q == CW'(DATA_BITS - 1) ? STOP : DATA;
        end
      end
      STOP: begin
        if (tick) scnt_d = last ? '0 : scnt_q + 1'b1;
        if (last) begin
          state_d = rxs_q ? IDLE : WAIT_HI;
          done    = rxs_q;
          ferr_d  = !rxs_q;
        end
      end
      WAIT_HI: state_d = rxs_q ? IDLE : WAIT_HI;
      default: state_d = IDLE;
    endcase
    // a full holding register keeps its byte unless it is drained in the same cycle
    data_d = (done && (!vld_q || rdy)) ? shift_q : data_q;
    vld_d  = done || (vld_q && !rdy);
    ovr_d  = done && vld_q && !rdy;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sync_q  <= 1'b1;
      rxs_q   <= 1'b1;
      prev_q  <= 1'b1;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= rxd;
      rxs_q   <= sync_q;
      prev_q  <= rxs_q;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx with hand-computed expectations
module tb_uart_rx;
  import uart_rx_pkg::*;
  logic        clk = 1'b0, rst = 1'b0, rxd = 1'b1, rdy = 1'b1;
  logic [15:0] baud_div = 16'd3;
  logic [7:0]  data;
  logic        vld, frame_err, overrun, busy, vld_p = 1'b0;
  logic [7:0]  rx_log [64];
  int n_chk = 0, n_bad = 0, cyc = 0, rx_n = 0, fe_n = 0, ov_n = 0, vld_cyc = 0;
  int rise_cyc = 0, stop_cyc = 0, b_rx, b_v, b_fe, b_ov;
  logic [7:0] f0 = 8'hF0;
  uart_rx dut (
    .clk       (clk),
    .rst       (rst),
    .baud_div  (baud_div),
    .rxd       (rxd),
    .rdy       (rdy),
    .data      (data),
    .vld       (vld),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (vld && rdy) begin
      rx_log[rx_n[5:0]] <= data;
      rx_n <= rx_n + 1;
    end
    if (vld && !vld_p) rise_cyc <= cyc;
    if (vld) vld_cyc <= vld_cyc + 1;
    if (frame_err) fe_n <= fe_n + 1;
    if (overrun) ov_n <= ov_n + 1;
    vld_p <= vld;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input int n);
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (n) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rxd = b[i];
      repeat (n) @(posedge clk);
    end
    #1 rxd = stop;
    stop_cyc = cyc;
    repeat (n) @(posedge clk);
  endtask
  task automatic mark();
    b_rx = rx_n; b_v = vld_cyc; b_fe = fe_n; b_ov = ov_n;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(data), 0);
    chk("rst_vld", 32'(vld), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    chk("rst_ovr", 32'(overrun), 0);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    mark();
    send(8'hA5, 1'b1, 64);
    repeat (40) @(posedge clk);
    #1;
    chk("a5_cnt", 32'(rx_n - b_rx), 1);
    chk("a5_log", 32'(rx_log[b_rx[5:0]]), 'hA5);
    chk("a5_port", 32'(data), 'hA5);
    chk("a5_lat", 32'(rise_cyc - stop_cyc), 35);
    chk("a5_vld1", 32'(vld_cyc - b_v), 1);
    chk("a5_ferr", 32'(fe_n - b_fe), 0);
    chk("a5_ovr", 32'(ov_n - b_ov), 0);
    mark();
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("gl_busy_hi", 32'(busy), 1);
    repeat (10) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("gl_busy_lo", 32'(busy), 0);
    chk("gl_state", 32'(dut.state_q), 32'(IDLE));
    chk("gl_novld", 32'(vld_cyc - b_v), 0);
    mark();
    send(8'h3C, 1'b0, 64);
    #1 rxd = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    chk("fe_pulse", 32'(fe_n - b_fe), 1);
    chk("fe_novld", 32'(vld_cyc - b_v), 0);
    chk("fe_wait", 32'(dut.state_q), 32'(WAIT_HI));
    chk("fe_busy", 32'(busy), 1);
    rxd = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("fe_idle", 32'(dut.state_q), 32'(IDLE));
    send(8'h55, 1'b1, 64);
    repeat (40) @(posedge clk);
    #1;
    chk("x55_cnt", 32'(rx_n - b_rx), 1);
    chk("x55_log", 32'(rx_log[b_rx[5:0]]), 'h55);
    chk("x55_fe1", 32'(fe_n - b_fe), 1);
    mark();
    rdy = 1'b0;
    send(8'h11, 1'b1, 64);
    send(8'h22, 1'b1, 64);
    repeat (40) @(posedge clk);
    #1;
    chk("ov_vld", 32'(vld), 1);
    chk("ov_data", 32'(data), 'h11);
    chk("ov_pulse", 32'(ov_n - b_ov), 1);
    chk("ov_ferr", 32'(fe_n - b_fe), 0);
    rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("ov_drop", 32'(vld), 0);
    chk("ov_take", 32'(rx_log[b_rx[5:0]]), 'h11);
    chk("ov_cnt", 32'(rx_n - b_rx), 1);
    mark();
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (64) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      #1 rxd = f0[i];
      repeat (i == 4 ? 32 : 64) @(posedge clk);
    end
    #1 chk("mr_busy", 32'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("mr_data", 32'(data), 0);
    chk("mr_vld", 32'(vld), 0);
    chk("mr_busy0", 32'(busy), 0);
    chk("mr_state", 32'(dut.state_q), 32'(IDLE));
    rxd = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    send(8'h0F, 1'b1, 64);
    repeat (40) @(posedge clk);
    #1;
    chk("x0f_cnt", 32'(rx_n - b_rx), 1);
    chk("x0f_log", 32'(rx_log[b_rx[5:0]]), 'h0F);
    chk("x0f_ferr", 32'(fe_n - b_fe), 0);
    mark();
    baud_div = 16'd0;
    send(8'h00, 1'b1, 16);
    send(8'hFF, 1'b1, 16);
    repeat (30) @(posedge clk);
    #1;
    chk("b2b_cnt", 32'(rx_n - b_rx), 2);
    chk("b2b_first", 32'(rx_log[b_rx[5:0]]), 'h00);
    chk("b2b_second", 32'(rx_log[6'(b_rx + 1)]), 'hFF);
    chk("b2b_ferr", 32'(fe_n - b_fe), 0);
    chk("b2b_ovr", 32'(ov_n - b_ov), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
